// File: rtl/picorv32_mem_arbiter_if.sv
// Bus bundle between the two requesters (CPU core, vector coprocessor), the arbiter
// and the shared system memory port.
interface picorv32_mem_arbiter_if;
  logic        cpu_mem_valid;
  logic        cpu_mem_instr;
  logic [31:0] cpu_mem_addr;
  logic [31:0] cpu_mem_wdata;
  logic [3:0]  cpu_mem_wstrb;
  logic        cpu_mem_ready;
  logic [31:0] cpu_mem_rdata;

  logic        vec_mem_valid;
  logic [31:0] vec_mem_addr;
  logic [31:0] vec_mem_wdata;
  logic [3:0]  vec_mem_wstrb;
  logic        vec_mem_ready;
  logic [31:0] vec_mem_rdata;

  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        grant_vec;
  logic        timeout_err;

  modport slave (
    input  cpu_mem_valid, cpu_mem_instr, cpu_mem_addr, cpu_mem_wdata, cpu_mem_wstrb,
    output cpu_mem_ready, cpu_mem_rdata,
    input  vec_mem_valid, vec_mem_addr, vec_mem_wdata, vec_mem_wstrb,
    output vec_mem_ready, vec_mem_rdata,
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata,
    output grant_vec, timeout_err
  );

  modport master (
    output cpu_mem_valid, cpu_mem_instr, cpu_mem_addr, cpu_mem_wdata, cpu_mem_wstrb,
    input  cpu_mem_ready, cpu_mem_rdata,
    output vec_mem_valid, vec_mem_addr, vec_mem_wdata, vec_mem_wstrb,
    input  vec_mem_ready, vec_mem_rdata,
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata,
    input  grant_vec, timeout_err
  );
endinterface

// File: rtl/picorv32_mem_arbiter.sv
// Shares one native memory port between the picorv32 core and the vector coprocessor:
// one transaction per grant, round-robin or vector-priority, with a stall timeout.
module picorv32_mem_arbiter #(
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 255
) (
  input logic                   clk,
  input logic                   reset,
  picorv32_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_CPU, BUSY_VEC} state_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  state_t      r_state;
  logic        r_last_vec;
  logic [15:0] r_wait_cnt;
  logic        r_timeout_err;

  logic w_busy;
  logic w_forced;
  logic w_done;
  logic w_pick_vec;

  assign w_busy   = (r_state != IDLE);
  // mem_ready has priority over an expiring timeout in the same cycle
  assign w_forced = w_busy && (TIMEOUT != 0) && (r_wait_cnt == TIMEOUT_CNT) && !bus.mem_ready;
  assign w_done   = w_busy && (bus.mem_ready || w_forced);

  always_comb begin
    if (bus.cpu_mem_valid && bus.vec_mem_valid)
      w_pick_vec = (ARB_MODE != 0) || !r_last_vec;
    else
      w_pick_vec = bus.vec_mem_valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_last_vec    <= 1'b1;
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cpu_mem_valid || bus.vec_mem_valid) begin
            r_state    <= w_pick_vec ? BUSY_VEC : BUSY_CPU;
            r_last_vec <= w_pick_vec;
            r_wait_cnt <= '0;
          end
        end
        BUSY_CPU, BUSY_VEC: begin
          if (w_done) begin
            r_state <= IDLE;
            if (w_forced)
              r_timeout_err <= 1'b1;
          end else if (r_wait_cnt != 16'hFFFF) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so an async reset clears them immediately
  always_comb begin
    bus.mem_valid     = w_busy && !w_forced;
    bus.mem_instr     = (r_state == BUSY_CPU) && bus.cpu_mem_instr;
    bus.mem_addr      = '0;
    bus.mem_wdata     = '0;
    bus.mem_wstrb     = '0;
    bus.cpu_mem_ready = 1'b0;
    bus.cpu_mem_rdata = '0;
    bus.vec_mem_ready = 1'b0;
    bus.vec_mem_rdata = '0;
    bus.grant_vec     = (r_state == BUSY_VEC);
    bus.timeout_err   = r_timeout_err;
    case (r_state)
      BUSY_CPU: begin
        bus.mem_addr      = bus.cpu_mem_addr;
        bus.mem_wdata     = bus.cpu_mem_wdata;
        bus.mem_wstrb     = bus.cpu_mem_wstrb;
        bus.cpu_mem_ready = w_done;
        bus.cpu_mem_rdata = bus.mem_ready ? bus.mem_rdata : 32'd0;
      end
      BUSY_VEC: begin
        bus.mem_addr      = bus.vec_mem_addr;
        bus.mem_wdata     = bus.vec_mem_wdata;
        bus.mem_wstrb     = bus.vec_mem_wstrb;
        bus.vec_mem_ready = w_done;
        bus.vec_mem_rdata = bus.mem_ready ? bus.mem_rdata : 32'd0;
      end
      default: ;
    endcase
  end

endmodule
